// File: rtl/gb_arb_pkg.sv
// Shared types and constants for the global-buffer PSUM arbiter.
package gb_arb_pkg;

    localparam int unsigned FRAME_W   = 6;
    // Wide enough for up to 16 PE-block requesters.
    localparam int unsigned TAG_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 is_pool;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin one-hot picker: the search starts at the stored pointer, which moves
// just past the winner whenever the grant is accepted.
module rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ));
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gb_psum_arb.sv
// Arbiter/sequencer sharing one single-port PSUM SRAM bank between PE blocks and pool.
// Define GB_ARB_PERF_CNT_EN to build the perf_grants access counter.
module gb_psum_arb
    import gb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned POOL_STARVE = 8
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          start,
    input  logic [FRAME_W-1:0]            cfg_num_frame,
    input  logic [FRAME_W-1:0]            cfg_num_block,
    input  logic                          blk_done,
    input  logic [NUM_REQ-1:0]            req_val,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdat,
    output logic [NUM_REQ-1:0]            rd_vld,
    output logic [DATA_WIDTH-1:0]         rd_dat,
    input  logic                          pool_val,
    output logic                          pool_rdy,
    input  logic [ADDR_WIDTH-1:0]         pool_addr,
    output logic                          pool_dvld,
    output logic                          sram_cen,
    output logic                          sram_wen,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_wdat,
    input  logic [DATA_WIDTH-1:0]         sram_rdat,
    output logic [FRAME_W-1:0]            cur_frame,
    output logic [FRAME_W-1:0]            cur_block,
    output logic                          busy,
    output logic                          patch_done,
    output logic [31:0]                   perf_grants
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SW    = $clog2(POOL_STARVE + 1);

    arb_state_e         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d, block_q, block_d;
    logic [FRAME_W-1:0] nf_q, nf_d, nb_q, nb_d;
    logic [SW-1:0]      starve_q, starve_d;
    rd_tag_t            tag_q, tag_d;

    logic [NUM_REQ-1:0] peb_gnt;
    logic [IDX_W-1:0]   peb_idx;
    logic               peb_any, run, pool_win, pool_go, peb_go;

    // Grants are suppressed during reset so no access races the state clear.
    assign run      = (state_q == RUN) && !Rst;
    assign pool_win = pool_val && (!peb_any || (starve_q == SW'(POOL_STARVE)));
    assign pool_go  = run && pool_win;
    assign peb_go   = run && peb_any && !pool_win;
    assign pool_rdy = pool_go;
    assign req_rdy  = peb_go ? peb_gnt : '0;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     (req_val),
        .en      (peb_go),
        .gnt     (peb_gnt),
        .gnt_idx (peb_idx),
        .any     (peb_any)
    );

    always_comb begin
        sram_cen  = pool_go || peb_go;
        sram_wen  = 1'b0;
        sram_addr = '0;
        sram_wdat = '0;
        if (pool_go) begin
            sram_addr = pool_addr;
        end else if (peb_go) begin
            sram_wen  = req_wr[peb_idx];
            sram_addr = req_addr[peb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdat = req_wdat[peb_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        tag_d.valid   = sram_cen && !sram_wen;
        tag_d.is_pool = pool_go;
        tag_d.idx     = TAG_IDX_W'(peb_idx);
    end

    // A return landing in a reset cycle is dropped.
    assign rd_vld    = (tag_q.valid && !tag_q.is_pool && !Rst) ? (NUM_REQ'(1) << tag_q.idx) : '0;
    assign pool_dvld = tag_q.valid && tag_q.is_pool && !Rst;
    assign rd_dat    = (tag_q.valid && !Rst) ? sram_rdat : '0;

    always_comb begin
        starve_d = starve_q;
        if (pool_go || !pool_val) begin
            starve_d = '0;
        end else if (peb_go && (starve_q != SW'(POOL_STARVE))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        block_d = block_q;
        nf_d    = nf_q;
        nb_d    = nb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    frame_d = '0;
                    block_d = '0;
                    nf_d    = cfg_num_frame;
                    nb_d    = cfg_num_block;
                end
            end
            RUN: begin
                if (blk_done) begin
                    if ((frame_q == nf_q) && (block_q == nb_q)) begin
                        state_d = DRAIN;
                    end else if (block_q == nb_q) begin
                        block_d = '0;
                        frame_d = frame_q + 1'b1;
                    end else begin
                        block_d = block_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!tag_q.valid) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            block_q  <= '0;
            nf_q     <= '0;
            nb_q     <= '0;
            starve_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            block_q  <= block_d;
            nf_q     <= nf_d;
            nb_q     <= nb_d;
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    assign cur_frame  = frame_q;
    assign cur_block  = block_q;
    assign busy       = (state_q != IDLE);
    assign patch_done = (state_q == DONE);

`ifdef GB_ARB_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_q <= '0;
        end else if (sram_cen) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_grants = perf_q;
`else
    assign perf_grants = '0;
`endif

endmodule

// File: tb/tb_gb_psum_arb.sv
// Randomised and directed bench for gb_psum_arb against a cycle-level behavioural model.
module tb_gb_psum_arb;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 512;
    localparam int PS = 8;
    localparam int SIDLE = 0, SRUN = 1, SDRAIN = 2, SDONE = 3;

    logic            Clk = 1'b0;
    logic            Rst, start, blk_done, pool_val, mem_init;
    logic [5:0]      cfg_num_frame, cfg_num_block, cur_frame, cur_block;
    logic [NR-1:0]   req_val, req_wr, req_rdy, rd_vld;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdat;
    logic [DW-1:0]   rd_dat, sram_wdat, sram_rdat;
    logic            pool_rdy, pool_dvld, sram_cen, sram_wen, busy, patch_done;
    logic [AW-1:0]   pool_addr, sram_addr;
    logic [31:0]     perf_grants;

    always #5 Clk = ~Clk;

    gb_psum_arb #(
        .NUM_REQ     (NR),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .POOL_STARVE (PS)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .start         (start),
        .cfg_num_frame (cfg_num_frame),
        .cfg_num_block (cfg_num_block),
        .blk_done      (blk_done),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdat      (req_wdat),
        .rd_vld        (rd_vld),
        .rd_dat        (rd_dat),
        .pool_val      (pool_val),
        .pool_rdy      (pool_rdy),
        .pool_addr     (pool_addr),
        .pool_dvld     (pool_dvld),
        .sram_cen      (sram_cen),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdat     (sram_wdat),
        .sram_rdat     (sram_rdat),
        .cur_frame     (cur_frame),
        .cur_block     (cur_block),
        .busy          (busy),
        .patch_done    (patch_done),
        .perf_grants   (perf_grants)
    );

    // SRAM bank: one access per cycle, read data one cycle later.
    logic [DW-1:0] mem [1024];
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= {16{32'(i)}};
        end else if (sram_cen) begin
            if (sram_wen) mem[sram_addr] <= sram_wdat;
            else          sram_rdat <= mem[sram_addr];
        end
    end

    // Behavioural model state.
    logic [DW-1:0] mmem [1024];
    int            m_state, m_frame, m_block, m_nf, m_nb, m_rr, m_starve, m_pend_idx;
    bit            m_pend, m_pend_pool;
    logic [DW-1:0] m_pend_dat;
    logic [31:0]   m_perf;
    int            g_peb;
    bit            g_pool;

    int n_vec = 0;
    int n_err = 0;

    logic [NR-1:0] obs_rdy, obs_rdvld;
    logic          obs_pool, obs_pdvld, obs_pdone, obs_busy;
    logic [5:0]    obs_frame, obs_block;
    logic [DW-1:0] obs_rddat;
    logic [31:0]   obs_perf;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = SIDLE; m_frame = 0; m_block = 0; m_nf = 0; m_nb = 0;
        m_rr = 0; m_starve = 0; m_pend = 0; m_pend_pool = 0; m_pend_idx = 0;
        m_pend_dat = '0; m_perf = '0;
    endtask

    task automatic model_eval();
        g_peb  = -1;
        g_pool = 0;
        if (m_state == SRUN && !Rst) begin
            if (pool_val && (req_val == '0 || m_starve == PS)) g_pool = 1;
            else
                for (int i = 0; i < NR; i++)
                    if (g_peb < 0 && req_val[(m_rr + i) % NR]) g_peb = (m_rr + i) % NR;
        end
    endtask

    task automatic model_update(input bit cen, input bit wen, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd);
        bit was_pend;
        was_pend = m_pend;
        if (Rst) begin
            model_reset();
            return;
        end
        m_pend = 0;
        if (cen) begin
            m_perf = m_perf + 1;
            if (wen) mmem[a] = wd;
            else begin
                m_pend = 1; m_pend_pool = g_pool; m_pend_idx = g_peb; m_pend_dat = mmem[a];
            end
        end
        if (g_pool || !pool_val) m_starve = 0;
        else if (g_peb >= 0 && m_starve < PS) m_starve++;
        if (g_peb >= 0) m_rr = (g_peb + 1) % NR;
        case (m_state)
            SIDLE: if (start) begin
                m_state = SRUN; m_frame = 0; m_block = 0;
                m_nf = int'(cfg_num_frame); m_nb = int'(cfg_num_block); m_perf = '0;
            end
            SRUN: if (blk_done) begin
                if (m_frame == m_nf && m_block == m_nb) m_state = SDRAIN;
                else if (m_block == m_nb) begin m_block = 0; m_frame++; end
                else m_block++;
            end
            SDRAIN: if (!was_pend) m_state = SDONE;
            default: m_state = SIDLE;
        endcase
    endtask

    // One clock: compare every output against the model mid-cycle, then advance it.
    task automatic step();
        logic [NR-1:0] e_rdy, e_rdvld;
        logic          e_cen, e_wen, e_pdvld;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdat, e_rddat;
        logic [31:0]   e_perf;
        @(negedge Clk);
        model_eval();
        e_rdy   = (g_peb >= 0) ? NR'(1) << g_peb : '0;
        e_cen   = g_pool || (g_peb >= 0);
        e_wen   = (g_peb >= 0) && req_wr[g_peb];
        e_addr  = g_pool ? pool_addr : (g_peb >= 0) ? req_addr[g_peb*AW +: AW] : '0;
        e_wdat  = (g_peb >= 0) ? req_wdat[g_peb*DW +: DW] : '0;
        e_rdvld = (m_pend && !m_pend_pool && !Rst) ? NR'(1) << m_pend_idx : '0;
        e_pdvld = m_pend && m_pend_pool && !Rst;
        e_rddat = (m_pend && !Rst) ? m_pend_dat : '0;
`ifdef GB_ARB_PERF_CNT_EN
        e_perf = m_perf;
`else
        e_perf = '0;
`endif
        chk("req_rdy", req_rdy, e_rdy);
        chk("pool_rdy", pool_rdy, g_pool);
        chk("sram_cen", sram_cen, e_cen);
        chk("sram_wen", sram_wen, e_wen);
        if (e_cen) chk("sram_addr", sram_addr, e_addr);
        if (e_wen) chk("sram_wdat", sram_wdat, e_wdat);
        chk("rd_vld", rd_vld, e_rdvld);
        chk("pool_dvld", pool_dvld, e_pdvld);
        chk("rd_dat", rd_dat, e_rddat);
        chk("busy", busy, m_state != SIDLE);
        chk("patch_done", patch_done, m_state == SDONE);
        chk("cur_frame", cur_frame, 6'(m_frame));
        chk("cur_block", cur_block, 6'(m_block));
        chk("perf_grants", perf_grants, e_perf);
        obs_rdy = req_rdy; obs_pool = pool_rdy; obs_rdvld = rd_vld; obs_pdvld = pool_dvld;
        obs_rddat = rd_dat; obs_pdone = patch_done; obs_busy = busy;
        obs_frame = cur_frame; obs_block = cur_block; obs_perf = perf_grants;
        model_update(e_cen, e_wen, e_addr, e_wdat);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rst = 0; start = 0; blk_done = 0; pool_val = 0; pool_addr = '0;
        req_val = '0; req_wr = '0; req_addr = '0; req_wdat = '0;
        cfg_num_frame = '0; cfg_num_block = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst = 1;
        step();
        Rst = 0;
    endtask

    task automatic begin_patch(input int nf, input int nb);
        cfg_num_frame = 6'(nf); cfg_num_block = 6'(nb);
        start = 1;
        step();
        start = 0;
    endtask

    initial begin
        int exp_f[5];
        int exp_b[5];
        logic [NR-1:0] rr_exp[10];
        int pulses, first;
        logic [DW-1:0] pat;
        logic [31:0] exp_perf;

        exp_f = '{0, 0, 1, 1, 1};
        exp_b = '{1, 2, 0, 1, 2};
        for (int i = 0; i < 1024; i++) mmem[i] = {16{32'(i)}};
        idle_inputs();
        Rst = 1; mem_init = 1;
        repeat (2) @(posedge Clk);
        #1;
        mem_init = 0;
        model_reset();

        // Reset state.
        do_reset();
        step();
        chk("rst_busy", obs_busy, 1'b0);
        chk("rst_frame", obs_frame, 6'd0);
        chk("rst_rdy", obs_rdy, 4'd0);

        // Frame/block sequencing.
        begin_patch(1, 2);
        for (int p = 0; p < 5; p++) begin
            blk_done = 1; step(); blk_done = 0; step();
            chk("seq_frame", obs_frame, 6'(exp_f[p]));
            chk("seq_block", obs_block, 6'(exp_b[p]));
        end
        blk_done = 1; step(); blk_done = 0;
        pulses = 0; first = -1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (obs_pdone) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        chk("pdone_count", 32'(pulses), 32'd1);
        chk("pdone_within2", (first >= 1 && first <= 2), 1'b1);
        chk("idle_after_patch", obs_busy, 1'b0);

        // Plain round robin, then pool anti-starvation.
        do_reset();
        begin_patch(63, 63);
        req_val = 4'hf;
        rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_order", obs_rdy, rr_exp[c]);
        end
        do_reset();
        begin_patch(63, 63);
        req_val = 4'hf; pool_val = 1; pool_addr = 10'd3;
        rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1};
        for (int c = 0; c < 10; c++) begin
            step();
            chk("starve_peb", obs_rdy, rr_exp[c]);
            chk("starve_pool", obs_pool, c == 8);
        end

        // Write by PEB2 then read back by PEB1.
        do_reset();
        begin_patch(63, 63);
        pat = {64{8'hA5}};
        req_val = 4'b0100; req_wr = 4'b0100;
        req_addr[2*AW +: AW] = 10'd5; req_wdat[2*DW +: DW] = pat;
        step();
        req_val = 4'b0010; req_wr = '0; req_addr[1*AW +: AW] = 10'd5;
        step();
        chk("rd_grant", obs_rdy, 4'b0010);
        req_val = '0;
        step();
        chk("rd_vld_peb1", obs_rdvld, 4'b0010);
        chk("rd_dat_peb1", obs_rddat, pat);

        // Reset right after a pool read grant.
        do_reset();
        begin_patch(3, 3);
        blk_done = 1; step(); blk_done = 0;
        pool_val = 1; pool_addr = 10'd7;
        step();
        chk("pool_grant", obs_pool, 1'b1);
        pool_val = 0; Rst = 1;
        step();
        chk("rst_pool_dvld", obs_pdvld, 1'b0);
        Rst = 0;
        step();
        chk("rst_mid_busy", obs_busy, 1'b0);
        chk("rst_mid_block", obs_block, 6'd0);
        chk("rst_mid_dvld", obs_pdvld, 1'b0);

        // Grant counter across a patch and a fresh start.
`ifdef GB_ARB_PERF_CNT_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        do_reset();
        begin_patch(0, 0);
        req_val = 4'b0001;
        repeat (10) step();
        req_val = '0; blk_done = 1; step(); blk_done = 0;
        repeat (4) step();
        chk("perf_count", obs_perf, exp_perf);
        begin_patch(0, 0);
        step();
        chk("perf_clear", obs_perf, 32'd0);

        // Randomised traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            Rst = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 19) == 0);
            cfg_num_frame = 6'($urandom_range(0, 3));
            cfg_num_block = 6'($urandom_range(0, 3));
            blk_done = ($urandom_range(0, 5) == 0);
            req_val = NR'($urandom);
            req_wr = NR'($urandom);
            for (int r = 0; r < NR; r++) req_addr[r*AW +: AW] = AW'($urandom_range(0, 15));
            for (int w = 0; w < NR*DW/32; w++) req_wdat[w*32 +: 32] = $urandom;
            if ($urandom_range(0, 9) == 0) pool_val = ~pool_val;
            pool_addr = AW'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gb_psum_arb.md
Name: gb_psum_arb

Overview:
Arbiter and sequencer in front of one global-buffer PSUM SRAM bank. It shares the single-port bank between NUM_REQ PE-block requesters (psum read/write) and one pool read requester, using round-robin with pool anti-starvation. It also tracks cur_frame/cur_block across one patch and signals patch completion to the CCU.

Parameters:
NUM_REQ, 4, number of PE-block requesters
ADDR_WIDTH, 10, SRAM word address width
DATA_WIDTH, 512, SRAM word width (16 x 32-bit psum)
POOL_STARVE, 8, max consecutive PEB grants while pool is waiting

Ports:
Clk  in  1  clock
Rst  in  1  synchronous reset, active-high
start  in  1  pulse; begin patch (IDLE only)
cfg_num_frame  in  6  frames per patch minus 1
cfg_num_block  in  6  blocks per frame minus 1
blk_done  in  1  pulse from CCU; current block finished
req_val  in  NUM_REQ  PEB request valid
req_rdy  out  NUM_REQ  PEB request granted (one-hot or 0)
req_wr  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses
req_wdat  in  NUM_REQ*DATA_WIDTH  packed write data
rd_vld  out  NUM_REQ  one-hot read-return strobe
rd_dat  out  DATA_WIDTH  shared read-return data
pool_val  in  1  pool read request
pool_rdy  out  1  pool request granted
pool_addr  in  ADDR_WIDTH  pool read address
pool_dvld  out  1  pool read-return strobe
sram_cen  out  1  SRAM access enable, active-high
sram_wen  out  1  1=write
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wdat  out  DATA_WIDTH  SRAM write data
sram_rdat  in  DATA_WIDTH  SRAM read data, 1-cycle latency
cur_frame  out  6  current frame index
cur_block  out  6  current block index
busy  out  1  state != IDLE
patch_done  out  1  one-cycle pulse at patch end
perf_grants  out  32  total grants (see Optional Feature)

Behaviour:
- Reset (Rst=1 at a Clk edge): state IDLE, all outputs 0, RR pointer 0, starve counter 0, in-flight read tag cleared.
- FSM states:
  - IDLE: start -> RUN; cur_frame/cur_block cleared to 0.
  - RUN: arbitrates every cycle.
  - DRAIN: no new grants; waits until no read is in flight -> DONE.
  - DONE: patch_done=1 for one cycle -> IDLE.
- Grants:
  - Issued only in RUN, at most one per cycle. req_rdy/pool_rdy are combinational from val and state; a transfer occurs when val&&rdy.
  - PEB selection is round-robin starting at rr_ptr. After a PEB grant to index k, rr_ptr=(k+1)%NUM_REQ.
  - Pool wins if pool_val and (no PEB valid or starve_cnt==POOL_STARVE).
  - starve_cnt increments on each PEB grant while pool_val=1, saturates at POOL_STARVE, and clears on a pool grant or when pool_val=0.
- SRAM drive: the granted request drives sram_* combinationally in the grant cycle. Pool requests are always reads.
- Read return: rd_dat=sram_rdat and the one-hot rd_vld (or pool_dvld) assert exactly 1 cycle after the read grant, via a registered tag. Writes produce no return.
- Sequencing on blk_done in RUN:
  - cur_block++. At cfg_num_block it wraps to 0 and cur_frame++.
  - If cur_frame==cfg_num_frame and cur_block==cfg_num_block, go to DRAIN; counters hold.
  - A grant in the same cycle as blk_done is still issued.
- Ignored inputs: blk_done outside RUN and start outside IDLE.
- Rst mid-patch: immediate IDLE. An in-flight read return is dropped, with no rd_vld.
- cfg_* are sampled only at start. A change during a patch has no effect.

Optional Feature:
- GB_ARB_PERF_CNT_EN:
  - Defined: perf_grants counts every SRAM access (wraps at 2^32), cleared by Rst and on start.
  - Undefined: perf_grants tied to 0 and the counter is not built.

Decomposition:
- Package gb_arb_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - FRAME_W=6
  - read-tag struct {valid, is_pool, idx}
- One sub-module, rr_arb: a NUM_REQ round-robin one-hot picker with pointer update.
- FSM, starve logic and frame/block counters stay in the top module.

Test Plan:
- Reset then start with cfg_num_frame=1, cfg_num_block=2, followed by 6 blk_done pulses. Expected:
  - (frame,block) steps (0,1),(0,2),(1,0),(1,1),(1,2).
  - The 6th pulse enters DRAIN, and patch_done pulses once within 2 cycles.
- All 4 req_val held high, pool idle, 8 cycles -> grants in order 0,1,2,3,0,1,2,3.
- All 4 PEBs plus pool_val held high -> pool granted on the 9th cycle (after 8 PEB grants), then PEB order resumes from rr_ptr.
- PEB2 write addr 5 data 0xA5..., then PEB1 read addr 5 -> rd_vld=4'b0010 one cycle after the grant, with rd_dat matching the written data.
- Rst asserted the cycle after a pool read grant -> pool_dvld stays 0, busy=0, cur_frame=cur_block=0 the next cycle.
- With GB_ARB_PERF_CNT_EN, 10 grants then start -> perf_grants=10, then 0 after start. Without the macro, perf_grants stays 0.
